// File: rtl/instmem_loader.sv
// Loads a program from a host word stream into the instruction memory write port,
// holding the core in reset during the load and reporting a running checksum.
module instmem_loader #(
    parameter int unsigned INST_LENGTH = 8,
    parameter int unsigned ADDR_WIDTH  = 6,
    parameter int unsigned N_LOCATIONS = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [ADDR_WIDTH:0]    prog_len,
    input  logic [INST_LENGTH-1:0] in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   mem_we,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    output logic [INST_LENGTH-1:0] mem_wdata,
    output logic                   core_hold,
    output logic                   busy,
    output logic                   done,
    output logic                   len_err,
    output logic [INST_LENGTH-1:0] checksum
);

    localparam int unsigned CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] MAX_LEN = CW'(N_LOCATIONS);

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH} state_t;

    state_t                 state, state_n;
    logic [CW-1:0]          len_r, len_n;
    logic [CW-1:0]          count, count_n;
    logic                   mem_we_n;
    logic [ADDR_WIDTH-1:0]  mem_addr_n;
    logic [INST_LENGTH-1:0] mem_wdata_n;
    logic [INST_LENGTH-1:0] checksum_n;
    logic                   busy_n;
    logic                   done_n;
    logic                   len_err_n;
    logic                   legal;

    // Ready is a pure state decode so the host sees it in the same cycle.
    assign in_ready = (state == LOAD);
    assign legal    = (prog_len != '0) && (prog_len <= MAX_LEN);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            len_r     <= '0;
            count     <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            checksum  <= '0;
            busy      <= 1'b0;
            core_hold <= 1'b0;
            done      <= 1'b0;
            len_err   <= 1'b0;
        end else begin
            state     <= state_n;
            len_r     <= len_n;
            count     <= count_n;
            mem_we    <= mem_we_n;
            mem_addr  <= mem_addr_n;
            mem_wdata <= mem_wdata_n;
            checksum  <= checksum_n;
            busy      <= busy_n;
            core_hold <= busy_n;
            done      <= done_n;
            len_err   <= len_err_n;
        end
    end

    always_comb begin
        state_n     = state;
        len_n       = len_r;
        count_n     = count;
        mem_we_n    = 1'b0;
        mem_addr_n  = mem_addr;
        mem_wdata_n = mem_wdata;
        checksum_n  = checksum;
        done_n      = 1'b0;
        len_err_n   = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    if (legal) begin
                        state_n    = LOAD;
                        len_n      = prog_len;
                        count_n    = '0;
                        checksum_n = '0;
                    end else begin
                        len_err_n = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (in_valid) begin
                    mem_we_n    = 1'b1;
                    mem_addr_n  = count[ADDR_WIDTH-1:0];
                    mem_wdata_n = in_data;
                    count_n     = count + CW'(1);
                    checksum_n  = checksum + in_data;
                    if (count == len_r - CW'(1)) begin
                        state_n = FLUSH;
                    end
                end
            end
            FLUSH: begin
                state_n = IDLE;
                done_n  = 1'b1;
            end
            default: state_n = IDLE;
        endcase

        busy_n = (state_n != IDLE);
    end

endmodule

// File: tb/tb_instmem_loader.sv
// Self-checking bench for instmem_loader: table of load scenarios, a write
// scoreboard, and hand sequences for length errors and mid-load reset.
module tb_instmem_loader;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [6:0] prog_len;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       mem_we;
    logic [5:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       core_hold;
    logic       busy;
    logic       done;
    logic       len_err;
    logic [7:0] checksum;

    instmem_loader dut (
        .clk(clk), .reset(reset), .start(start), .prog_len(prog_len),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .core_hold(core_hold), .busy(busy), .done(done), .len_err(len_err),
        .checksum(checksum)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         len;
        logic [7:0] base;
        logic [7:0] step;
        bit         gap;
        bit         mid_start;
        bit         hold;
        logic [7:0] exp_sum;
    } vec_t;

    typedef struct {
        logic [5:0] addr;
        logic [7:0] data;
    } wr_t;

    vec_t vecs[5];
    wr_t  exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_writes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every write the DUT issues must match the oldest outstanding expected write.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            n_writes++;
            if (exp_q.size() == 0) begin
                check("unexpected_write", {26'd0, mem_addr}, 32'hFFFF_FFFF);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                check("write_addr", {26'd0, mem_addr}, {26'd0, w.addr});
                check("write_data", {24'd0, mem_wdata}, {24'd0, w.data});
            end
        end
    end

    task automatic run_load(input vec_t v);
        int w0;
        logic [7:0] w;
        w0 = n_writes;
        @(negedge clk);
        start = 1'b1;
        prog_len = 7'(v.len);
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", {31'd0, busy}, 32'd1);
        check("hold_after_start", {31'd0, core_hold}, 32'd1);
        check("ready_after_start", {31'd0, in_ready}, 32'd1);
        for (int i = 0; i < v.len; i++) begin
            if (v.gap && i > 0) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
            w = 8'(int'(v.base) + int'(v.step) * i);
            in_valid = 1'b1;
            in_data  = w;
            exp_q.push_back('{addr: 6'(i), data: w});
            if (v.mid_start && i == 2) begin
                start = 1'b1;
                prog_len = 7'd3;
            end
            @(negedge clk);
            start = 1'b0;
        end
        // Cycle after the last acceptance: FLUSH
        if (v.hold) begin
            in_valid = 1'b1;
            in_data  = 8'hEE;
        end else begin
            in_valid = 1'b0;
        end
        check("flush_ready", {31'd0, in_ready}, 32'd0);
        check("flush_hold", {31'd0, core_hold}, 32'd1);
        check("flush_we", {31'd0, mem_we}, 32'd1);
        check("flush_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        check("done_pulse", {31'd0, done}, 32'd1);
        check("done_busy", {31'd0, busy}, 32'd0);
        check("done_hold", {31'd0, core_hold}, 32'd0);
        check("checksum", {24'd0, checksum}, {24'd0, v.exp_sum});
        check("write_count", n_writes - w0, v.len);
        check("queue_drained", exp_q.size(), 0);
        @(negedge clk);
        check("done_single", {31'd0, done}, 32'd0);
        check("idle_ready", {31'd0, in_ready}, 32'd0);
        if (v.hold) begin
            repeat (2) @(negedge clk);
            check("held_word_ignored", n_writes - w0, v.len);
            check("held_checksum", {24'd0, checksum}, {24'd0, v.exp_sum});
        end
    endtask

    task automatic len_err_case(input logic [6:0] len, input logic [7:0] sum);
        int w0;
        w0 = n_writes;
        @(negedge clk);
        start = 1'b1;
        prog_len = len;
        @(negedge clk);
        start = 1'b0;
        check("len_err_pulse", {31'd0, len_err}, 32'd1);
        check("len_err_busy", {31'd0, busy}, 32'd0);
        check("len_err_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        check("len_err_clear", {31'd0, len_err}, 32'd0);
        check("len_err_sum", {24'd0, checksum}, {24'd0, sum});
        check("len_err_nowrite", n_writes - w0, 0);
    endtask

    task automatic reset_case();
        @(negedge clk);
        start = 1'b1;
        prog_len = 7'd5;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h50 + i);
            exp_q.push_back('{addr: 6'(i), data: 8'(8'h50 + i)});
            @(negedge clk);
        end
        in_valid = 1'b0;
        reset = 1'b1;
        start = 1'b1;
        prog_len = 7'd2;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_hold", {31'd0, core_hold}, 32'd0);
        check("rst_ready", {31'd0, in_ready}, 32'd0);
        check("rst_we", {31'd0, mem_we}, 32'd0);
        check("rst_addr", {26'd0, mem_addr}, 32'd0);
        check("rst_wdata", {24'd0, mem_wdata}, 32'd0);
        check("rst_sum", {24'd0, checksum}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_queue", exp_q.size(), 0);
        repeat (3) begin
            @(negedge clk);
            check("rst_no_done", {31'd0, done}, 32'd0);
            check("rst_stays_idle", {31'd0, busy}, 32'd0);
        end
    endtask

    initial begin
        vecs[0] = '{len: 4,  base: 8'h11, step: 8'h11, gap: 1'b0, mid_start: 1'b0, hold: 1'b0, exp_sum: 8'hAA};
        vecs[1] = '{len: 64, base: 8'h00, step: 8'h01, gap: 1'b1, mid_start: 1'b0, hold: 1'b0, exp_sum: 8'hE0};
        vecs[2] = '{len: 5,  base: 8'h01, step: 8'h01, gap: 1'b0, mid_start: 1'b1, hold: 1'b1, exp_sum: 8'h0F};
        vecs[3] = '{len: 2,  base: 8'hFF, step: 8'h03, gap: 1'b0, mid_start: 1'b0, hold: 1'b0, exp_sum: 8'h01};
        vecs[4] = '{len: 3,  base: 8'h10, step: 8'h10, gap: 1'b0, mid_start: 1'b0, hold: 1'b0, exp_sum: 8'h60};

        reset = 1'b1;
        start = 1'b0;
        prog_len = '0;
        in_data = '0;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("reset_ready", {31'd0, in_ready}, 32'd0);
        check("reset_we", {31'd0, mem_we}, 32'd0);
        check("reset_addr", {26'd0, mem_addr}, 32'd0);
        check("reset_wdata", {24'd0, mem_wdata}, 32'd0);
        check("reset_hold", {31'd0, core_hold}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_len_err", {31'd0, len_err}, 32'd0);
        check("reset_sum", {24'd0, checksum}, 32'd0);

        for (int k = 0; k < 5; k++) begin
            if (k == 1) begin
                len_err_case(7'd0, 8'hAA);
                len_err_case(7'd65, 8'hAA);
            end
            if (k == 4) begin
                in_valid = 1'b0;
                reset_case();
            end
            run_load(vecs[k]);
        end
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("final_queue", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
